// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and byte-lane merge helper for the register file scoreboard
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_READ = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    // Widest data word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Replace the byte lanes of old_val selected by be with the matching lanes of new_val.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] new_val,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_val;
        for (int k = 0; k < MAX_BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with write bypass and busy lookup
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS,
    parameter int DEPTH    = 2**ADDR_W
)(
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   regs [DEPTH],
    input  logic [DEPTH-1:0]    busy_vec,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_busy
);

    logic              is_zero;
    logic              bypass_hit;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] merged;

    // Decode the addressed register and detect a same-cycle write to it.
    always_comb begin
        is_zero    = (ZERO_REG != 0) && (rd_addr == '0);
        stored     = regs[rd_addr];
        bypass_hit = (BYPASS != 0) && wr_en && !rst && !is_zero && (wr_addr == rd_addr);
        merged     = DATA_W'(byte_merge(MAX_DATA_W'(stored), MAX_DATA_W'(wr_data), MAX_BE_W'(wr_be)));
    end

    // Select forwarded, stored or zero data, and mask busy when the pending write lands now.
    always_comb begin
        rd_data = stored;
        rd_busy = busy_vec[rd_addr];
        if (rst || is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (bypass_hit) begin
            rd_data = merged;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - byte-writable register file with pending-write scoreboard
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
    output logic [NUM_READ*DATA_W-1:0] rd_data,
    output logic [NUM_READ-1:0]        rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [2**ADDR_W-1:0]       busy_vec,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   pend_next;
    logic [DATA_W-1:0] wr_merged;
    logic              wr_ok;

    // Writes to the hardwired zero register are dropped; others merge by byte lane.
    always_comb begin
        wr_ok     = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
        wr_merged = DATA_W'(byte_merge(MAX_DATA_W'(regs[wr_addr]), MAX_DATA_W'(wr_data), MAX_BE_W'(wr_be)));
    end

    // Register storage; reset clears every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    // Next scoreboard: a write clears its bit, an issue sets it and wins a same-address tie.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_next[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    // Popcount of the next scoreboard so pend_cnt can be registered alongside it.
    always_comb begin
        pend_next = '0;
        for (int r = 0; r < DEPTH; r++) begin
            pend_next = pend_next + {{ADDR_W{1'b0}}, busy_next[r]};
        end
    end

    // Scoreboard and pending count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_next;
            pend_cnt <= pend_next;
        end
    end

    assign busy_vec = busy;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .rst      (rst),
            .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs     (regs),
            .busy_vec (busy),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .wr_be    (wr_be),
            .rd_data  (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[i])
        );
    end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_READ, default 2, number of independent read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 is hardwired zero.
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port rd_addr  input  NUM_READ*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  output  NUM_READ*DATA_W  packed read data, same packing.
REQ-010 SHALL have port rd_busy  output  NUM_READ  scoreboard-pending flag of each addressed register.
REQ-011 SHALL have port wr_en  input  1  write strobe.
REQ-012 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-013 SHALL have port wr_data  input  DATA_W  write data.
REQ-014 SHALL have port wr_be  input  DATA_W/8  byte enables; bit k covers wr_data[8k+7:8k].
REQ-015 SHALL have port iss_en  input  1  issue strobe: marks a register as having a pending write.
REQ-016 SHALL have port iss_addr  input  ADDR_W  issue destination address.
REQ-017 SHALL have port busy_vec  output  2**ADDR_W  registered scoreboard, bit r = register r pending.
REQ-018 SHALL have port pend_cnt  output  ADDR_W+1  registered count of set bits in busy_vec.

Function
REQ-019 On a clk edge with wr_en=1, SHALL update only byte lanes of register wr_addr whose wr_be bit is 1; other lanes keep their value.
REQ-020 With ZERO_REG=1: writes to address 0 ignored, reads of address 0 return 0, busy bit 0 never set, rd_busy for address 0 always 0.
REQ-021 Reads SHALL be combinational, zero latency, every port independent; ports may address the same register.
REQ-022 With BYPASS=1 and wr_en=1, wr_addr==rd_addr_i (and not zero-reg): rd_data_i = stored value with enabled lanes replaced by wr_data; BYPASS=0 returns the stored value.
REQ-023 busy bit r SHALL set on a clk edge with iss_en=1, iss_addr==r; SHALL clear on a clk edge with wr_en=1, wr_addr==r (regardless of wr_be, including all-zero).
REQ-024 Simultaneous issue and write to the same address: set wins; bit ends 1 and data is still written.
REQ-025 Issue to an already-busy register: bit stays 1; no nesting or counting per register.
REQ-026 Write to a non-busy register: data written; bit stays 0; no error.
REQ-027 rd_busy_i = busy[rd_addr_i], forced 0 when BYPASS=1 and a same-cycle write targets rd_addr_i (same-cycle issue does not affect rd_busy).
REQ-028 pend_cnt SHALL equal the popcount of busy_vec every cycle; range 0..2**ADDR_W (ZERO_REG=1: max 2**ADDR_W-1); never wraps.

Reset
REQ-029 rst=1 SHALL asynchronously clear all registers to 0, busy_vec to 0, pend_cnt to 0, independent of clk.
REQ-030 While rst=1, writes and issues SHALL be ignored; rd_data returns 0 for all addresses (bypass suppressed).
REQ-031 Reset mid-operation SHALL discard all pending scoreboard entries; first edge after deassertion operates normally.

Structure
REQ-032 Default parameter values and the byte-merge function (old, new, be) SHALL live in shared package reg_file_pkg.
REQ-033 SHALL instantiate sub-module rf_read_port NUM_READ times, each holding the address decode, bypass merge and rd_busy logic for one port.
REQ-034 Storage, scoreboard and pend_cnt SHALL be in reg_file_scoreboard only; pend_cnt registered, not recomputed combinationally on the output.

Verification
REQ-035 Reset then write r5=0xDEADBEEF, be=4'hF; next cycle read r5 on both ports -> 0xDEADBEEF; read r0 -> 0.
REQ-036 r7=0x11223344, write be=4'b0101 data 0xAABBCCDD -> r7=0x11BB33DD; same cycle with BYPASS=1 rd_data shows 0x11BB33DD, BYPASS=0 shows 0x11223344.
REQ-037 Issue r3, r4, r3 on consecutive cycles -> busy_vec bits 3,4 set, pend_cnt=2; write r3 -> pend_cnt=1, rd_busy(r3) 0 in write cycle.
REQ-038 Same cycle iss_en r9 and wr_en r9 (busy) -> after edge busy[9]=1, data updated, pend_cnt unchanged.
REQ-039 Issue to r0 and write 0xFFFFFFFF to r0 -> busy[0]=0, r0 reads 0, pend_cnt unchanged.
REQ-040 Issue all 31 non-zero registers, assert rst between clk edges -> busy_vec=0, pend_cnt=0, all reads 0 immediately.
